// File: rtl/mem_port_pkg.sv
// Shared types and helpers for the multi-channel byte-serial memory port.
package mem_port_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_IO_WAIT = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  // Attributes of the accepted request, held for the whole transfer.
  typedef struct packed {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] wdata;
  } xfer_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [2:0] byte_count(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      F3_W:        return 3'd4;
      default:     return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      F3_B:    return {{24{raw[7]}}, raw[7:0]};
      F3_H:    return {{16{raw[15]}}, raw[15:0]};
      F3_BU:   return {24'b0, raw[7:0]};
      F3_HU:   return {16'b0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_rr_arbiter.sv
// NUM_CH-way request arbiter; MEM_PORT_ARB_RR_EN selects round-robin,
// otherwise fixed priority with the lowest index winning.
module mem_port_rr_arbiter
  import mem_port_pkg::*;
#(
  parameter  int unsigned NUM_CH = 2,
  localparam int unsigned IDX_W  = idx_width(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              advance_i,
  output logic              gnt_valid_c_o,
  output logic [IDX_W-1:0]  gnt_idx_c_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx;
  logic             found;
  logic [IDX_W-1:0] win;

  // Scan channels starting at the pointer; first requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = IDX_W'((32'(ptr_q) + i) % NUM_CH);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign gnt_valid_c_o = found;
  assign gnt_idx_c_o   = win;

  always_comb begin
    ptr_d = ptr_q;
`ifdef MEM_PORT_ARB_RR_EN
    if (advance_i && found) ptr_d = IDX_W'((32'(win) + 32'd1) % NUM_CH);
`else
    // Fixed priority keeps the scan anchored at channel 0.
    if (advance_i) ptr_d = '0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Multi-channel byte-serial RAM port: arbitrates requesters and splits each
// access into byte cycles. Arbitration policy selected by MEM_PORT_ARB_RR_EN.
module mem_port_arbiter
  import mem_port_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned IO_SEL_HI = 17
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_wr,
  input  logic [3*NUM_CH-1:0]      req_type,
  input  logic [ADDR_W*NUM_CH-1:0] req_addr,
  input  logic [32*NUM_CH-1:0]     req_wdata,
  input  logic [NUM_CH-1:0]        flush_in,
  output logic [NUM_CH-1:0]        resp_valid,
  output logic [31:0]              resp_data,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wr,
  input  logic                     io_buffer_full
);

  localparam int unsigned CH_W = idx_width(NUM_CH);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  xfer_t               attr_q, attr_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [23:0]         rdata_q, rdata_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                mem_wr_q, mem_wr_d;
  logic [NUM_CH-1:0]   resp_valid_q, resp_valid_d;

  logic                gnt_valid, hs, io_stall, load_flush, last_byte;
  logic [CH_W-1:0]     gnt_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [31:0]         sel_wdata, raw;
  logic [2:0]          sel_f3, nbytes, cnt_nxt;
  logic                sel_wr;

  mem_port_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk_i        (clk_in),
    .rst_n_i      (rst_n_in),
    .req_i        (req_valid & ~flush_in),
    .advance_i    (hs),
    .gnt_valid_c_o(gnt_valid),
    .gnt_idx_c_o  (gnt_idx)
  );

  // Mux out the granted channel's request fields.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_f3    = '0;
    sel_wr    = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == CH_W'(i)) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*32 +: 32];
        sel_f3    = req_type[i*3 +: 3];
        sel_wr    = req_wr[i];
      end
    end
  end

  assign hs         = rst_n_in && rdy_in && (state_q == ST_IDLE) && gnt_valid;
  assign io_stall   = sel_wr && (sel_addr[IO_SEL_HI -: 2] == 2'b11) && io_buffer_full;
  assign nbytes     = byte_count(attr_q.f3);
  assign cnt_nxt    = cnt_q + 3'd1;
  assign last_byte  = (cnt_q == nbytes - 3'd1);
  assign load_flush = !attr_q.wr && flush_in[ch_q];

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      case (state_q)
        ST_IDLE:    if (hs) state_d = io_stall ? ST_IO_WAIT : ST_XFER;
        ST_XFER:    if (load_flush) state_d = ST_IDLE;
                    else if (last_byte) state_d = ST_RESP;
        ST_IO_WAIT: if (!io_buffer_full) state_d = ST_XFER;
        ST_RESP:    state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and registered outputs; everything holds while rdy_in is low.
  always_comb begin
    ch_d         = ch_q;
    addr_d       = addr_q;
    attr_d       = attr_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    resp_valid_d = resp_valid_q;
    if (rdy_in) begin
      case (state_q)
        ST_IDLE: begin
          resp_valid_d = '0;
          mem_wr_d     = 1'b0;
          if (hs) begin
            ch_d    = gnt_idx;
            addr_d  = sel_addr;
            attr_d  = '{wr: sel_wr, f3: sel_f3, wdata: sel_wdata};
            cnt_d   = 3'd0;
            rdata_d = '0;
            if (!io_stall) begin
              mem_a_d    = sel_addr;
              mem_dout_d = sel_wdata[7:0];
              mem_wr_d   = sel_wr;
            end
          end
        end
        ST_IO_WAIT: begin
          if (!io_buffer_full) begin
            mem_a_d    = addr_q;
            mem_dout_d = attr_q.wdata[7:0];
            mem_wr_d   = attr_q.wr;
          end
        end
        ST_XFER: begin
          // RAM returns byte k-1 while byte k is being addressed.
          case (cnt_q)
            3'd1:    rdata_d[7:0]   = mem_din;
            3'd2:    rdata_d[15:8]  = mem_din;
            3'd3:    rdata_d[23:16] = mem_din;
            default: ;
          endcase
          if (load_flush || last_byte) begin
            mem_wr_d = 1'b0;
            if (!load_flush) resp_valid_d[ch_q] = 1'b1;
          end else begin
            cnt_d      = cnt_nxt;
            mem_a_d    = addr_q + ADDR_W'(cnt_nxt);
            mem_dout_d = 8'(attr_q.wdata >> {cnt_nxt, 3'b000});
            mem_wr_d   = attr_q.wr;
          end
        end
        ST_RESP: resp_valid_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ch_q         <= '0;
      addr_q       <= '0;
      attr_q       <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      ch_q         <= ch_d;
      addr_q       <= addr_d;
      attr_q       <= attr_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Final byte arrives in RESP and is merged combinationally.
  always_comb begin
    case (nbytes)
      3'd1:    raw = {24'b0, mem_din};
      3'd2:    raw = {16'b0, mem_din, rdata_q[7:0]};
      default: raw = {mem_din, rdata_q};
    endcase
    resp_data = (state_q == ST_RESP && !attr_q.wr) ? load_extend(attr_q.f3, raw) : 32'b0;
  end

  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign mem_wr     = mem_wr_q;
  assign resp_valid = resp_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-wide RAM model;
// expected grant order follows MEM_PORT_ARB_RR_EN.
module tb_mem_port_arbiter;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned ADDR_W = 32;

  logic                     clk_in;
  logic                     rst_n_in;
  logic                     rdy_in;
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH-1:0]        req_wr;
  logic [3*NUM_CH-1:0]      req_type;
  logic [ADDR_W*NUM_CH-1:0] req_addr;
  logic [32*NUM_CH-1:0]     req_wdata;
  logic [NUM_CH-1:0]        flush_in;
  logic [NUM_CH-1:0]        resp_valid;
  logic [31:0]              resp_data;
  logic [7:0]               mem_din;
  logic [7:0]               mem_dout;
  logic [ADDR_W-1:0]        mem_a;
  logic                     mem_wr;
  logic                     io_buffer_full;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ch;

  logic [7:0] ram [0:1023];

  mem_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .IO_SEL_HI(17)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .rdy_in        (rdy_in),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wr        (req_wr),
    .req_type      (req_type),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .flush_in      (flush_in),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .mem_din       (mem_din),
    .mem_dout      (mem_dout),
    .mem_a         (mem_a),
    .mem_wr        (mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // RAM model: synchronous read, one cycle of latency; reloaded during reset.
  always @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
      ram[10'h100] <= 8'h11;
      ram[10'h101] <= 8'h22;
      ram[10'h102] <= 8'h33;
      ram[10'h103] <= 8'h44;
      mem_din      <= 8'h00;
    end else begin
      if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
      mem_din <= ram[mem_a[9:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input int ch, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_wr[ch]             = wr;
    req_type[ch*3 +: 3]    = f3;
    req_addr[ch*32 +: 32]  = addr;
    req_wdata[ch*32 +: 32] = wd;
    req_valid[ch]          = 1'b1;
  endtask

  // Load: handshake, n byte cycles with consecutive addresses, then response.
  task automatic do_load(input int ch, input logic [2:0] f3, input logic [31:0] addr,
                         input int n, input logic [31:0] exp, input string tag);
    set_req(ch, 1'b0, f3, addr, 32'h0);
    @(negedge clk_in);
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << ch));
    next_cycle();
    req_valid = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_in);
      check({tag, "_addr"}, mem_a, addr + 32'(k));
      check({tag, "_wr"}, 32'(mem_wr), 32'h0);
      next_cycle();
    end
    @(negedge clk_in);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'(1 << ch));
    check({tag, "_resp_data"}, resp_data, exp);
    next_cycle();
  endtask

  initial begin
    rst_n_in       = 1'b0;
    rdy_in         = 1'b1;
    req_valid      = '1;
    req_wr         = '0;
    req_type       = '0;
    req_addr       = '0;
    req_wdata      = '0;
    flush_in       = '0;
    io_buffer_full = 1'b0;

    // Reset state, with requests pending
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    req_valid = '0;
    rst_n_in  = 1'b1;
    next_cycle();

    // Word load from channel 0
    do_load(0, 3'b010, 32'h100, 4, 32'h4433_2211, "lw");

    // Unaligned halfword store from channel 1
    set_req(1, 1'b1, 3'b001, 32'h201, 32'h0000_BEEF);
    @(negedge clk_in);
    check("sh_ready", 32'(req_ready), 32'h2);
    next_cycle();
    req_valid = '0;
    @(negedge clk_in);
    check("sh_a0", mem_a, 32'h201);
    check("sh_wr0", 32'(mem_wr), 32'h1);
    check("sh_d0", 32'(mem_dout), 32'hEF);
    next_cycle();
    @(negedge clk_in);
    check("sh_a1", mem_a, 32'h202);
    check("sh_wr1", 32'(mem_wr), 32'h1);
    check("sh_d1", 32'(mem_dout), 32'hBE);
    next_cycle();
    @(negedge clk_in);
    check("sh_resp_valid", 32'(resp_valid), 32'h2);
    check("sh_resp_data", resp_data, 32'h0);
    check("sh_wr_off", 32'(mem_wr), 32'h0);
    next_cycle();

    // Read back with sign and zero extension
    do_load(1, 3'b001, 32'h201, 2, 32'hFFFF_BEEF, "lh");
    do_load(1, 3'b101, 32'h201, 2, 32'h0000_BEEF, "lhu");
    do_load(1, 3'b000, 32'h202, 1, 32'hFFFF_FFBE, "lb");
    do_load(1, 3'b100, 32'h202, 1, 32'h0000_00BE, "lbu");

    // Both channels requesting continuously
    set_req(0, 1'b0, 3'b000, 32'h100, 32'h0);
    set_req(1, 1'b0, 3'b000, 32'h101, 32'h0);
    for (int g = 0; g < 4; g++) begin
`ifdef MEM_PORT_ARB_RR_EN
      exp_ch = g % 2;
`else
      exp_ch = 0;
`endif
      @(negedge clk_in);
      check("arb_grant", 32'(req_ready), 32'(1 << exp_ch));
      next_cycle();
      next_cycle();
      @(negedge clk_in);
      check("arb_resp_valid", 32'(resp_valid), 32'(1 << exp_ch));
      check("arb_resp_data", resp_data, (exp_ch == 1) ? 32'h22 : 32'h11);
      next_cycle();
    end
    req_valid = '0;

    // Byte store to IO while the UART buffer is full for 3 cycles
    io_buffer_full = 1'b1;
    set_req(0, 1'b1, 3'b000, 32'h3_0000, 32'h0000_005A);
    @(negedge clk_in);
    check("io_ready", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      check("io_wait_wr", 32'(mem_wr), 32'h0);
      next_cycle();
      if (k == 1) io_buffer_full = 1'b0;
    end
    @(negedge clk_in);
    check("io_wr", 32'(mem_wr), 32'h1);
    check("io_addr", mem_a, 32'h3_0000);
    check("io_dout", 32'(mem_dout), 32'h5A);
    next_cycle();
    @(negedge clk_in);
    check("io_resp_valid", 32'(resp_valid), 32'h1);
    check("io_resp_data", resp_data, 32'h0);
    next_cycle();

    // Flush during the second byte cycle of a word load
    set_req(0, 1'b0, 3'b010, 32'h100, 32'h0);
    @(negedge clk_in);
    check("fl_ready", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = '0;
    @(negedge clk_in);
    check("fl_a0", mem_a, 32'h100);
    next_cycle();
    flush_in = 2'b01;
    @(negedge clk_in);
    check("fl_a1", mem_a, 32'h101);
    check("fl_resp_pre", 32'(resp_valid), 32'h0);
    next_cycle();
    flush_in = '0;
    set_req(1, 1'b0, 3'b000, 32'h101, 32'h0);
    @(negedge clk_in);
    check("fl_no_resp", 32'(resp_valid), 32'h0);
    check("fl_next_ready", 32'(req_ready), 32'h2);
    check("fl_wr", 32'(mem_wr), 32'h0);
    next_cycle();
    req_valid = '0;
    @(negedge clk_in);
    check("fl_next_addr", mem_a, 32'h101);
    next_cycle();
    @(negedge clk_in);
    check("fl_next_resp_valid", 32'(resp_valid), 32'h2);
    check("fl_next_resp_data", resp_data, 32'h22);
    next_cycle();

    // Flush coincident with a request masks it
    set_req(0, 1'b0, 3'b000, 32'h100, 32'h0);
    flush_in = 2'b01;
    @(negedge clk_in);
    check("fl_mask_ready", 32'(req_ready), 32'h0);
    next_cycle();
    req_valid = '0;
    flush_in  = '0;

    // rdy_in low blocks handshakes, then freezes a word load
    rdy_in = 1'b0;
    set_req(0, 1'b0, 3'b010, 32'h100, 32'h0);
    @(negedge clk_in);
    check("frz_idle_ready", 32'(req_ready), 32'h0);
    next_cycle();
    rdy_in = 1'b1;
    @(negedge clk_in);
    check("frz_ready", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = '0;
    @(negedge clk_in);
    check("frz_a0", mem_a, 32'h100);
    next_cycle();
    rdy_in = 1'b0;
    @(negedge clk_in);
    check("frz_a1", mem_a, 32'h101);
    next_cycle();
    @(negedge clk_in);
    check("frz_hold1", mem_a, 32'h101);
    check("frz_hold_ready", 32'(req_ready), 32'h0);
    next_cycle();
    rdy_in = 1'b1;
    @(negedge clk_in);
    check("frz_hold2", mem_a, 32'h101);
    next_cycle();
    @(negedge clk_in);
    check("frz_thaw", mem_a, 32'h102);

    // Asynchronous reset in the middle of the transfer
    #2;
    rst_n_in  = 1'b0;
    req_valid = '1;
    #1;
    check("arst_ready", 32'(req_ready), 32'h0);
    check("arst_mem_a", mem_a, 32'h0);
    check("arst_mem_dout", 32'(mem_dout), 32'h0);
    check("arst_mem_wr", 32'(mem_wr), 32'h0);
    check("arst_resp_valid", 32'(resp_valid), 32'h0);
    check("arst_resp_data", resp_data, 32'h0);
    @(negedge clk_in);
    req_valid = '0;
    rst_n_in  = 1'b1;
    next_cycle();

    do_load(0, 3'b000, 32'h100, 1, 32'h11, "post_rst_lb");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
